// File: rtl/ew_join_issue_vec4.sv
// ew_join_issue_vec4
// Issue stage in front of the EMA update stage. It buffers a lam tile stream
// (Q0.16 unsigned) and a u tile stream (Q8.8 signed, with a start-of-sequence
// flag) in two small FIFOs, joins them one-for-one, attaches the state address
// and presents the result on a registered valid/ready port.
// Optional build macro: LAM_CLAMP_EN -- when defined, every lam element above
// LAM_MAX is replaced by LAM_MAX as it is loaded into the output register.
module ew_join_issue_vec4 #(
  parameter int TILE_SIZE  = 4,
  parameter int W          = 16,
  parameter int S_ADDR_W   = 10,
  parameter int FIFO_DEPTH = 2,
  parameter logic [W-1:0] LAM_MAX = 16'hFF00
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      lam_valid,
  output logic                      lam_ready,
  input  logic [W*TILE_SIZE-1:0]    lam_in,
  input  logic                      u_valid,
  output logic                      u_ready,
  input  logic [W*TILE_SIZE-1:0]    u_in,
  input  logic                      u_sof,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [W*TILE_SIZE-1:0]    lam_vec,
  output logic [W*TILE_SIZE-1:0]    u_vec,
  output logic [S_ADDR_W-1:0]       s_addr,
  output logic                      out_sof
);

  localparam int VW = W * TILE_SIZE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]         PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [S_ADDR_W-1:0] ADDR_ONE = {{(S_ADDR_W-1){1'b0}}, 1'b1};

`ifdef LAM_CLAMP_EN
  localparam logic CLAMP_ON = 1'b1;
`else
  localparam logic CLAMP_ON = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // lam FIFO: pointers carry one extra wrap bit to tell full from empty.
  // ---------------------------------------------------------------------------
  logic [VW-1:0] lam_mem_q [FIFO_DEPTH];
  logic [AW:0]   lam_wp_q, lam_wp_d, lam_rp_q, lam_rp_d;
  logic          lam_full_s, lam_empty_s, lam_push_s;
  logic [VW-1:0] lam_head_s;

  // ---------------------------------------------------------------------------
  // u FIFO: each entry is {sof, u tile}.
  // ---------------------------------------------------------------------------
  logic [VW:0]   u_mem_q [FIFO_DEPTH];
  logic [AW:0]   u_wp_q, u_wp_d, u_rp_q, u_rp_d;
  logic          u_full_s, u_empty_s, u_push_s;
  logic [VW:0]   u_head_s;

  // Output register and address counter.
  logic                load_s;
  logic                out_valid_q, out_valid_d;
  logic [VW-1:0]       lam_vec_q, lam_vec_d;
  logic [VW-1:0]       u_vec_q, u_vec_d;
  logic [S_ADDR_W-1:0] s_addr_q, s_addr_d;
  logic                out_sof_q, out_sof_d;
  logic [S_ADDR_W-1:0] cnt_q, cnt_d;
  logic [S_ADDR_W-1:0] addr_next_s;
  logic [VW-1:0]       lam_load_s;

  // FIFO status, handshakes and the join condition.
  always_comb begin
    lam_full_s  = (lam_wp_q[AW] != lam_rp_q[AW]) &&
                  (lam_wp_q[AW-1:0] == lam_rp_q[AW-1:0]);
    lam_empty_s = (lam_wp_q == lam_rp_q);
    u_full_s    = (u_wp_q[AW] != u_rp_q[AW]) &&
                  (u_wp_q[AW-1:0] == u_rp_q[AW-1:0]);
    u_empty_s   = (u_wp_q == u_rp_q);
    lam_head_s  = lam_mem_q[lam_rp_q[AW-1:0]];
    u_head_s    = u_mem_q[u_rp_q[AW-1:0]];
    // Ready depends only on stored occupancy, so a full FIFO never accepts
    // a push even in the cycle it is being popped.
    lam_push_s  = lam_valid && !lam_full_s;
    u_push_s    = u_valid && !u_full_s;
    load_s      = !lam_empty_s && !u_empty_s && (!out_valid_q || out_ready);
  end

  // Next-state for the FIFO pointers; both FIFOs pop together on load.
  always_comb begin
    lam_wp_d = lam_wp_q;
    lam_rp_d = lam_rp_q;
    u_wp_d   = u_wp_q;
    u_rp_d   = u_rp_q;
    if (lam_push_s) begin
      lam_wp_d = lam_wp_q + PTR_ONE;
    end else begin
      lam_wp_d = lam_wp_q;
    end
    if (u_push_s) begin
      u_wp_d = u_wp_q + PTR_ONE;
    end else begin
      u_wp_d = u_wp_q;
    end
    if (load_s) begin
      lam_rp_d = lam_rp_q + PTR_ONE;
      u_rp_d   = u_rp_q + PTR_ONE;
    end else begin
      lam_rp_d = lam_rp_q;
      u_rp_d   = u_rp_q;
    end
  end

  // Optional lam ceiling applied element-wise on the way into the output reg.
  always_comb begin
    lam_load_s = lam_head_s;
    for (int i = 0; i < TILE_SIZE; i++) begin
      if (CLAMP_ON && (lam_head_s[i*W +: W] > LAM_MAX)) begin
        lam_load_s[i*W +: W] = LAM_MAX;
      end else begin
        lam_load_s[i*W +: W] = lam_head_s[i*W +: W];
      end
    end
  end

  // Address for the token being loaded: restart at 0 on sof, else chain on.
  always_comb begin
    if (u_head_s[VW]) begin
      addr_next_s = {S_ADDR_W{1'b0}};
    end else begin
      addr_next_s = cnt_q + ADDR_ONE;
    end
  end

  // Next-state for the output register; fields hold while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    lam_vec_d   = lam_vec_q;
    u_vec_d     = u_vec_q;
    s_addr_d    = s_addr_q;
    out_sof_d   = out_sof_q;
    cnt_d       = cnt_q;
    if (load_s) begin
      out_valid_d = 1'b1;
      lam_vec_d   = lam_load_s;
      u_vec_d     = u_head_s[VW-1:0];
      s_addr_d    = addr_next_s;
      out_sof_d   = u_head_s[VW];
      cnt_d       = addr_next_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // FIFO storage writes; contents need no reset since pointers gate them.
  always_ff @(posedge clk) begin
    if (lam_push_s) begin
      lam_mem_q[lam_wp_q[AW-1:0]] <= lam_in;
    end
    if (u_push_s) begin
      u_mem_q[u_wp_q[AW-1:0]] <= {u_sof, u_in};
    end
  end

  // State registers: pointers, output register and address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lam_wp_q    <= {(AW+1){1'b0}};
      lam_rp_q    <= {(AW+1){1'b0}};
      u_wp_q      <= {(AW+1){1'b0}};
      u_rp_q      <= {(AW+1){1'b0}};
      out_valid_q <= 1'b0;
      lam_vec_q   <= {VW{1'b0}};
      u_vec_q     <= {VW{1'b0}};
      s_addr_q    <= {S_ADDR_W{1'b0}};
      out_sof_q   <= 1'b0;
      cnt_q       <= {S_ADDR_W{1'b1}};
    end else begin
      lam_wp_q    <= lam_wp_d;
      lam_rp_q    <= lam_rp_d;
      u_wp_q      <= u_wp_d;
      u_rp_q      <= u_rp_d;
      out_valid_q <= out_valid_d;
      lam_vec_q   <= lam_vec_d;
      u_vec_q     <= u_vec_d;
      s_addr_q    <= s_addr_d;
      out_sof_q   <= out_sof_d;
      cnt_q       <= cnt_d;
    end
  end

  assign lam_ready = !lam_full_s;
  assign u_ready   = !u_full_s;
  assign out_valid = out_valid_q;
  assign lam_vec   = lam_vec_q;
  assign u_vec     = u_vec_q;
  assign s_addr    = s_addr_q;
  assign out_sof   = out_sof_q;

endmodule

// File: tb/tb_ew_join_issue_vec4.sv
// Testbench for ew_join_issue_vec4 (built with S_ADDR_W=3 so address wrap is
// reachable quickly). Token records come from a table; a source queue per
// stream drives the inputs and a scoreboard queue holds the expected outputs.
module tb_ew_join_issue_vec4;

  localparam int SAW = 3;
  localparam int VW  = 64;
  localparam int NT  = 39;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           lam_valid, lam_ready, u_valid, u_ready, u_sof;
  logic           out_valid, out_ready, out_sof;
  logic [VW-1:0]  lam_in, u_in, lam_vec, u_vec;
  logic [SAW-1:0] s_addr;

  always #5 clk = ~clk;

  ew_join_issue_vec4 #(.S_ADDR_W(SAW)) dut (
    .clk(clk), .rst_n(rst_n),
    .lam_valid(lam_valid), .lam_ready(lam_ready), .lam_in(lam_in),
    .u_valid(u_valid), .u_ready(u_ready), .u_in(u_in), .u_sof(u_sof),
    .out_valid(out_valid), .out_ready(out_ready),
    .lam_vec(lam_vec), .u_vec(u_vec), .s_addr(s_addr), .out_sof(out_sof)
  );

  typedef struct {
    logic [VW-1:0]  lam;
    logic [VW-1:0]  u;
    logic           sof;
    logic [SAW-1:0] addr;
  } vec_t;

  vec_t          tbl [NT];
  vec_t          exp_q [$];
  logic [VW-1:0] lam_src [$];
  logic [VW:0]   u_src [$];

  int total = 0;
  int bad   = 0;
  logic lam_en = 1'b1, u_en = 1'b1, rdy_fix = 1'b1, rdy_rand = 1'b0;
  int lam_acc_n = 0, u_acc_n = 0, run = 0, max_run = 0;
  logic prev_acc = 1'b0, hold_prev = 1'b0;
  logic [VW-1:0]  h_lam, h_u;
  logic [SAW-1:0] h_addr;
  logic           h_sof;

  int addr_c [NT] = '{0,1,2,3,4,5,6,7, 0,1,2, 3,4,5,
                      0,1,2,3,4,5,6,7,0,1, 2,3,4,5,6,0,1,2,3,4, 5, 6,7,0, 0};

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  function automatic logic [63:0] exp_lam(logic [63:0] l);
    logic [63:0] r;
    r = l;
`ifdef LAM_CLAMP_EN
    for (int i = 0; i < 4; i++) begin
      if (r[i*16 +: 16] > 16'hFF00) r[i*16 +: 16] = 16'hFF00;
    end
`endif
    return r;
  endfunction

  task automatic drive_inputs();
    lam_valid = lam_en && (lam_src.size() != 0);
    lam_in    = (lam_src.size() != 0) ? lam_src[0] : 64'h0;
    u_valid   = u_en && (u_src.size() != 0);
    u_in      = (u_src.size() != 0) ? u_src[0][VW-1:0] : 64'h0;
    u_sof     = (u_src.size() != 0) ? u_src[0][VW] : 1'b0;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
  endtask

  task automatic push_tok(int i, bit with_exp);
    lam_src.push_back(tbl[i].lam);
    u_src.push_back({tbl[i].sof, tbl[i].u});
    if (with_exp) exp_q.push_back(tbl[i]);
  endtask

  // One clock: sample at the falling edge, update sources after the rising edge.
  task automatic tick();
    logic la, ua, oa;
    vec_t e;
    @(negedge clk);
    la = lam_valid && lam_ready;
    ua = u_valid && u_ready;
    oa = out_valid && out_ready;
    if (hold_prev) begin
      chk("hold_lam", lam_vec, h_lam);
      chk("hold_u", u_vec, h_u);
      chk("hold_addr", 64'(s_addr), 64'(h_addr));
      chk("hold_sof", 64'(out_sof), 64'(h_sof));
    end
    hold_prev = out_valid && !out_ready;
    h_lam = lam_vec; h_u = u_vec; h_addr = s_addr; h_sof = out_sof;
    if (oa) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'(out_valid), 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("lam_vec", lam_vec, exp_lam(e.lam));
        chk("u_vec", u_vec, e.u);
        chk("out_sof", 64'(out_sof), 64'(e.sof));
        chk("s_addr", 64'(s_addr), 64'(e.addr));
      end
      run = prev_acc ? run + 1 : 1;
      if (run > max_run) max_run = run;
    end
    prev_acc = oa;
    if (la) lam_acc_n++;
    if (ua) u_acc_n++;
    @(posedge clk);
    #1;
    if (la) void'(lam_src.pop_front());
    if (ua) void'(u_src.pop_front());
    drive_inputs();
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'h0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NT; i++) begin
      tbl[i].lam  = {16'h1000 + 16'(i), 16'h2000 + 16'(i),
                     16'h3000 + 16'(i), 16'h4000 + 16'(i)};
      tbl[i].u    = {16'h8000 + 16'(i), 16'hFF00 + 16'(i),
                     16'h0100 + 16'(i), 16'h7F00 + 16'(i)};
      tbl[i].sof  = (i == 0) || (i == 14) || (i == 29);
      tbl[i].addr = 3'(addr_c[i]);
    end
    tbl[34].lam = {16'hFFFF, 16'hFF01, 16'hFF00, 16'h1234};

    // T1: reset state, then one pair and its two-cycle latency.
    rst_n = 1'b0; lam_valid = 1'b0; u_valid = 1'b0; u_sof = 1'b0;
    lam_in = 64'h0; u_in = 64'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_lam", lam_vec, 64'h0);
    chk("rst_u", u_vec, 64'h0);
    chk("rst_addr", 64'(s_addr), 64'h0);
    chk("rst_sof", 64'(out_sof), 64'h0);
    chk("rst_ready", {62'h0, lam_ready, u_ready}, 64'h3);
    rst_n = 1'b1;
    @(posedge clk); #1;
    lam_valid = 1'b1; lam_in = {4{16'h8000}};
    u_valid = 1'b1; u_in = {4{16'h0100}}; u_sof = 1'b1;
    @(posedge clk); #1;
    lam_valid = 1'b0; u_valid = 1'b0; u_sof = 1'b0;
    chk("t1_lat1", 64'(out_valid), 64'h0);
    @(posedge clk); #1;
    chk("t1_lat2", 64'(out_valid), 64'h1);
    chk("t1_addr", 64'(s_addr), 64'h0);
    chk("t1_sof", 64'(out_sof), 64'h1);
    chk("t1_lam", lam_vec, {4{16'h8000}});
    chk("t1_u", u_vec, {4{16'h0100}});
    @(posedge clk); #1;
    chk("t1_hold", lam_vec, {4{16'h8000}});
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t1_drained", 64'(out_valid), 64'h0);

    // T2: 8 back-to-back tokens, no bubbles.
    for (int i = 0; i < 8; i++) push_tok(i, 1'b1);
    max_run = 0; drive_inputs();
    drain(40);
    chk("t2_run", 64'(max_run), 64'd8);

    // T3: lam runs 3 tokens ahead of u.
    u_en = 1'b0; lam_acc_n = 0; u_acc_n = 0;
    for (int i = 8; i < 11; i++) push_tok(i, 1'b1);
    drive_inputs();
    repeat (5) tick();
    chk("t3_lam_acc", 64'(lam_acc_n), 64'd2);
    chk("t3_lam_ready", 64'(lam_ready), 64'h0);
    chk("t3_u_acc", 64'(u_acc_n), 64'h0);
    u_en = 1'b1; drive_inputs();
    drain(40);

    // T4: downstream stall fills both FIFOs, then drains in order.
    rdy_fix = 1'b0;
    for (int i = 11; i < 14; i++) push_tok(i, 1'b1);
    drive_inputs();
    repeat (5) tick();
    chk("t4_valid", 64'(out_valid), 64'h1);
    chk("t4_lam_ready", 64'(lam_ready), 64'h0);
    chk("t4_u_ready", 64'(u_ready), 64'h0);
    rdy_fix = 1'b1; drive_inputs();
    drain(40);

    // T5: address wrap, then a sof mid-sequence under random backpressure.
    for (int i = 14; i < 24; i++) push_tok(i, 1'b1);
    drive_inputs();
    drain(60);
    rdy_rand = 1'b1;
    for (int i = 24; i < 34; i++) push_tok(i, 1'b1);
    drive_inputs();
    drain(200);
    rdy_rand = 1'b0;

    // T6: lam ceiling (or pass-through), then reset mid-stream.
    push_tok(34, 1'b1);
    drive_inputs();
    drain(20);
    rdy_fix = 1'b0;
    for (int i = 35; i < 38; i++) push_tok(i, 1'b0);
    drive_inputs();
    repeat (3) tick();
    chk("t6_pre_valid", 64'(out_valid), 64'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'h0);
    chk("t6_rst_ready", {62'h0, lam_ready, u_ready}, 64'h3);
    lam_src.delete(); u_src.delete(); hold_prev = 1'b0;
    rdy_fix = 1'b1; drive_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("t6_idle_valid", 64'(out_valid), 64'h0);
    push_tok(38, 1'b1);
    drive_inputs();
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
